// File: rtl/align_shift_stage_pkg.sv
// Shared widths, the aligned-operand bundle and the shift-amount helper
// for the floating-point add/sub alignment stage.
package align_shift_stage_pkg;

  localparam int EXP_W     = 8;
  localparam int FRAC_W    = 23;
  localparam int MANT_W    = 24;
  localparam int GRS_W     = 3;
  localparam int ALIGN_W   = 27;
  localparam int SHIFT_SAT = 27;
  localparam int AMT_W     = 9;

  typedef struct packed {
    logic [EXP_W-1:0]   e_big;
    logic [MANT_W-1:0]  m_big;
    logic [ALIGN_W-1:0] m_small;
    logic               s_big;
    logic               s_small;
    logic               swap;
  } align_t;

  // carry=0 with difference=0 means the true distance is 256
  function automatic logic [AMT_W-1:0] shift_amount(
    input logic             carry,
    input logic [EXP_W-1:0] difference
  );
    logic [EXP_W-1:0] neg;
    neg = ~difference + 8'd1;
    if (carry)
      return {1'b0, difference};
    else if (difference == '0)
      return 9'd256;
    else
      return {1'b0, neg};
  endfunction

endpackage

// File: rtl/align_shift_stage_rshift_sticky.sv
// Saturating right shift of the aligned mantissa; every bit shifted out
// is folded into the sticky bit at position 0.
module rshift_sticky
  import align_shift_stage_pkg::*;
(
  input  logic [ALIGN_W-1:0] data,
  input  logic [AMT_W-1:0]   amount,
  output logic [ALIGN_W-1:0] result
);

  localparam logic [AMT_W-1:0] SAT = AMT_W'(SHIFT_SAT);

  logic [ALIGN_W-1:0] lost_mask;
  logic [ALIGN_W-1:0] shifted;
  logic               sticky;

  always_comb begin
    lost_mask = '0;
    shifted   = '0;
    sticky    = 1'b0;
    result    = '0;
    if (amount >= SAT) begin
      result = {{(ALIGN_W-1){1'b0}}, |data};
    end else begin
      lost_mask = ~({ALIGN_W{1'b1}} << amount[4:0]);
      shifted   = data >> amount[4:0];
      sticky    = |(data & lost_mask);
      result    = {shifted[ALIGN_W-1:1], shifted[0] | sticky};
    end
  end

endmodule

// File: rtl/align_shift_stage.sv
// Operand swap and mantissa alignment for FP add, held in one
// valid/ready pipeline slot.
module align_shift_stage
  import align_shift_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              carry,
  input  logic [EXP_W-1:0]  difference,
  input  logic [EXP_W-1:0]  Ex,
  input  logic [EXP_W-1:0]  Ey,
  input  logic              zero_Ex,
  input  logic              zero_Ey,
  input  logic [FRAC_W-1:0] Mx,
  input  logic [FRAC_W-1:0] My,
  input  logic              Sx,
  input  logic              Sy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  E_big,
  output logic [MANT_W-1:0] M_big,
  output logic [ALIGN_W-1:0] M_small,
  output logic              S_big,
  output logic              S_small,
  output logic              swap
);

  logic [EXP_W-1:0]   ex_eff;
  logic [EXP_W-1:0]   ey_eff;
  logic [MANT_W-1:0]  mant_x;
  logic [MANT_W-1:0]  mant_y;
  logic [MANT_W-1:0]  mant_small;
  logic [AMT_W-1:0]   amount;
  logic [ALIGN_W-1:0] aligned;
  align_t             nxt;
  align_t             q;
  logic               valid_q;
  logic               take;

  assign ex_eff = zero_Ex ? 8'd1 : Ex;
  assign ey_eff = zero_Ey ? 8'd1 : Ey;
  assign mant_x = {~zero_Ex, Mx};
  assign mant_y = {~zero_Ey, My};

  assign amount     = shift_amount(carry, difference);
  assign mant_small = carry ? mant_y : mant_x;

  rshift_sticky u_rshift (
    .data   ({mant_small, {GRS_W{1'b0}}}),
    .amount (amount),
    .result (aligned)
  );

  always_comb begin
    nxt         = '0;
    nxt.swap    = ~carry;
    nxt.e_big   = carry ? ex_eff : ey_eff;
    nxt.m_big   = carry ? mant_x : mant_y;
    nxt.s_big   = carry ? Sx : Sy;
    nxt.s_small = carry ? Sy : Sx;
    nxt.m_small = aligned;
  end

  assign in_ready = ~valid_q | out_ready;
  assign take     = in_valid & in_ready;

  // reset wins over any transfer on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      q       <= '0;
    end else if (take) begin
      valid_q <= 1'b1;
      q       <= nxt;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign E_big     = q.e_big;
  assign M_big     = q.m_big;
  assign M_small   = q.m_small;
  assign S_big     = q.s_big;
  assign S_small   = q.s_small;
  assign swap      = q.swap;

endmodule

// File: tb/tb_align_shift_stage.sv
// Directed-vector bench for align_shift_stage: alignment values,
// handshake stalls and reset behaviour.
module tb_align_shift_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        carry;
  logic [7:0]  difference;
  logic [7:0]  Ex, Ey;
  logic        zero_Ex, zero_Ey;
  logic [22:0] Mx, My;
  logic        Sx, Sy;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  E_big;
  logic [23:0] M_big;
  logic [26:0] M_small;
  logic        S_big, S_small, swap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  align_shift_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .carry      (carry),
    .difference (difference),
    .Ex         (Ex),
    .Ey         (Ey),
    .zero_Ex    (zero_Ex),
    .zero_Ey    (zero_Ey),
    .Mx         (Mx),
    .My         (My),
    .Sx         (Sx),
    .Sy         (Sy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .E_big      (E_big),
    .M_big      (M_big),
    .M_small    (M_small),
    .S_big      (S_big),
    .S_small    (S_small),
    .swap       (swap)
  );

  task automatic set_ops(
    input logic c, input logic [7:0] d,
    input logic [7:0] ex, input logic [7:0] ey,
    input logic zx, input logic zy,
    input logic [22:0] mx, input logic [22:0] my,
    input logic sx, input logic sy
  );
    carry = c; difference = d; Ex = ex; Ey = ey;
    zero_Ex = zx; zero_Ey = zy; Mx = mx; My = my; Sx = sx; Sy = sy;
  endtask

  // present one operand set with out_ready=1 and sample after the edge
  task automatic push_one();
    @(negedge clk);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    set_ops(1'b1, 8'h02, 8'h82, 8'h80, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs: out_valid=%b in_ready=%b, want 0 1",
               out_valid, in_ready);
    end
    checks++;
    if ({E_big, M_big, M_small, S_big, S_small, swap} !== '0) begin
      errors++;
      $display("FAIL reset_data: E=%h Mb=%h Ms=%h, want all 0",
               E_big, M_big, M_small);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_align_pos();
    set_ops(1'b1, 8'h02, 8'h82, 8'h80, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    push_one();
    checks++;
    if (out_valid !== 1'b1 || E_big !== 8'h82 || swap !== 1'b0) begin
      errors++;
      $display("FAIL pos_ctrl: v=%b E=%h swap=%b, want 1 82 0",
               out_valid, E_big, swap);
    end
    checks++;
    if (M_big !== 24'h800000 || M_small !== 27'h1000000) begin
      errors++;
      $display("FAIL pos_mant: Mb=%h Ms=%h, want 800000 1000000",
               M_big, M_small);
    end
    checks++;
    if (S_big !== 1'b0 || S_small !== 1'b1) begin
      errors++;
      $display("FAIL pos_sign: Sb=%b Ss=%b, want 0 1", S_big, S_small);
    end
  endtask

  task automatic test_align_neg();
    set_ops(1'b0, 8'hFA, 8'h7F, 8'h85, 1'b0, 1'b0,
            23'h000001, '0, 1'b0, 1'b1);
    push_one();
    checks++;
    if (swap !== 1'b1 || E_big !== 8'h85 || M_big !== 24'h800000) begin
      errors++;
      $display("FAIL neg_big: swap=%b E=%h Mb=%h, want 1 85 800000",
               swap, E_big, M_big);
    end
    checks++;
    if (M_small !== 27'h0100001) begin
      errors++;
      $display("FAIL neg_small: Ms=%h, want 0100001", M_small);
    end
    checks++;
    if (S_big !== 1'b1 || S_small !== 1'b0) begin
      errors++;
      $display("FAIL neg_sign: Sb=%b Ss=%b, want 1 0", S_big, S_small);
    end
  endtask

  task automatic test_sticky();
    set_ops(1'b1, 8'h40, 8'hC0, 8'h80, 1'b0, 1'b0,
            '0, 23'h000001, 1'b0, 1'b0);
    push_one();
    checks++;
    if (M_small !== 27'h0000001) begin
      errors++;
      $display("FAIL sticky_only: Ms=%h, want 0000001", M_small);
    end
    set_ops(1'b1, 8'h40, 8'hC0, 8'h00, 1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
    push_one();
    checks++;
    if (M_small !== 27'h0) begin
      errors++;
      $display("FAIL sticky_zero: Ms=%h, want 0", M_small);
    end
    // exact boundary: shift 26 keeps hidden bit in position 0
    set_ops(1'b1, 8'd26, 8'h9A, 8'h80, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    push_one();
    checks++;
    if (M_small !== 27'h0000001) begin
      errors++;
      $display("FAIL shift26: Ms=%h, want 0000001", M_small);
    end
    set_ops(1'b1, 8'd25, 8'h99, 8'h80, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    push_one();
    checks++;
    if (M_small !== 27'h0000002) begin
      errors++;
      $display("FAIL shift25: Ms=%h, want 0000002", M_small);
    end
    // carry=0 with difference=0 means a 256-place shift
    set_ops(1'b0, 8'h00, 8'h10, 8'h10, 1'b0, 1'b0,
            23'h000005, 23'h000003, 1'b0, 1'b0);
    push_one();
    checks++;
    if (swap !== 1'b1 || M_small !== 27'h0000001 ||
        M_big !== 24'h800003) begin
      errors++;
      $display("FAIL shift256: swap=%b Ms=%h Mb=%h, want 1 1 800003",
               swap, M_small, M_big);
    end
  endtask

  task automatic test_denorm();
    set_ops(1'b1, 8'h00, 8'h01, 8'h00, 1'b0, 1'b1,
            23'h123456, 23'h00000F, 1'b0, 1'b0);
    push_one();
    checks++;
    if (E_big !== 8'h01 || M_big !== 24'h923456) begin
      errors++;
      $display("FAIL denorm_big: E=%h Mb=%h, want 01 923456", E_big, M_big);
    end
    checks++;
    if (M_small !== 27'h0000078) begin
      errors++;
      $display("FAIL denorm_small: Ms=%h, want 0000078", M_small);
    end
    set_ops(1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1,
            23'h000100, 23'h000001, 1'b1, 1'b0);
    push_one();
    checks++;
    if (E_big !== 8'h01 || M_big !== 24'h000100 ||
        M_small !== 27'h0000008 || S_big !== 1'b1) begin
      errors++;
      $display("FAIL denorm_both: E=%h Mb=%h Ms=%h Sb=%b, want 01 000100 8 1",
               E_big, M_big, M_small, S_big);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] tags [4];
    logic       rdy  [4];
    logic [7:0] expq [$];
    logic [7:0] got  [$];
    logic [7:0] held;
    int         idx;
    logic       fire_in;
    tags = '{8'h10, 8'h20, 8'h30, 8'h40};
    rdy  = '{1'b1, 1'b0, 1'b0, 1'b1};
    idx  = 0;
    held = '0;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      out_ready = (c < 4) ? rdy[c] : 1'b1;
      in_valid = (c < 4);
      set_ops(1'b1, 8'h00, tags[idx], 8'h01, 1'b0, 1'b0,
              '0, '0, 1'b0, 1'b0);
      #1;
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_ready: cycle %0d in_ready=%b, want 0",
                   c, in_ready);
        end
        if (c == 2) begin
          checks++;
          if (E_big !== held) begin
            errors++;
            $display("FAIL b2b_stable: E=%h, want %h", E_big, held);
          end
        end
      end
      if (out_valid && out_ready) got.push_back(E_big);
      fire_in = in_valid & in_ready;
      if (fire_in) begin
        expq.push_back(tags[idx]);
        idx++;
      end
      @(posedge clk);
      #1;
      held = E_big;
    end
    in_valid = 1'b0;
    checks++;
    if (got.size() != 2 || expq.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: got=%0d accepted=%0d, want 2 2",
               got.size(), expq.size());
    end else begin
      checks++;
      if (got[0] !== 8'h10 || got[1] !== 8'h20) begin
        errors++;
        $display("FAIL b2b_order: got %h %h, want 10 20", got[0], got[1]);
      end
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_reset_stall();
    set_ops(1'b0, 8'hFE, 8'h80, 8'h82, 1'b0, 1'b0,
            23'h7FFFFF, 23'h000001, 1'b1, 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre: v=%b rdy=%b, want 1 0", out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        {E_big, M_big, M_small, S_big, S_small, swap} !== '0) begin
      errors++;
      $display("FAIL rst_stall: v=%b rdy=%b E=%h Ms=%h, want 0 1 0 0",
               out_valid, in_ready, E_big, M_small);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_release: v=%b rdy=%b, want 0 1",
               out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_align_pos();
    test_align_neg();
    test_sticky();
    test_denorm();
    test_back_to_back();
    test_reset_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
